// File: rtl/dip_pkg.sv
// rtl/dip_pkg.sv - shared constants, FSM encoding and round-robin pick for the DIP scheduler
package dip_pkg;

    localparam int NUM_SW = 7;
    localparam logic [2:0] LED_OFF = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_NEXT  = 2'd2
    } state_t;

    // First requesting index strictly after 'last', wrapping 6 -> 0; 'last' itself is checked last.
    function automatic logic [2:0] rr_pick(input logic [NUM_SW-1:0] req, input logic [2:0] last);
        logic [2:0] pick;
        int idx;
        pick = last;
        for (int k = NUM_SW; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_SW;
            if (req[idx]) pick = 3'(idx);
        end
        return pick;
    endfunction

endpackage

// File: rtl/dip_debounce.sv
// rtl/dip_debounce.sv - two-flop synchronizer plus stable-count debouncer for one switch
module dip_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb
);

    localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            deb <= 1'b0;
            cnt <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            // any cycle where the synchronized input agrees with the output restarts the count
            if (s2 == deb) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                deb <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/dip_rr_scheduler.sv
// rtl/dip_rr_scheduler.sv - round-robin time-slot scheduler giving one debounced DIP switch the LEDs
module dip_rr_scheduler
    import dip_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SLOT_CYCLES     = 50000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_SW-1:0] sw,
    output logic [2:0]        led,
    output logic [NUM_SW-1:0] grant,
    output logic              busy
);

    localparam int SCW = (SLOT_CYCLES < 2) ? 1 : $clog2(SLOT_CYCLES + 1);
    localparam logic [SCW-1:0] SLOT_LAST = SCW'(SLOT_CYCLES - 1);

    logic [NUM_SW-1:0] req;
    state_t            state;
    state_t            state_n;
    logic [2:0]        owner;
    logic [SCW-1:0]    slot_cnt;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_deb
        dip_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk(clk),
            .rst(rst),
            .raw(sw[i]),
            .deb(req[i])
        );
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  if (|req) state_n = ST_SERVE;
            ST_SERVE: if (!req[owner] || slot_cnt == SLOT_LAST) state_n = ST_NEXT;
            ST_NEXT:  state_n = (|req) ? ST_SERVE : ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            owner    <= 3'd6;
            slot_cnt <= '0;
            grant    <= '0;
            led      <= LED_OFF;
            busy     <= 1'b0;
        end else begin
            state <= state_n;
            if (state_n == ST_SERVE && state != ST_SERVE) begin
                owner    <= rr_pick(req, owner);
                slot_cnt <= '0;
            end else if (state == ST_SERVE) begin
                slot_cnt <= slot_cnt + 1'b1;
            end
            // outputs trail the state register by one edge, which sets the DEBOUNCE_CYCLES+4 latency
            grant <= (state == ST_SERVE) ? (NUM_SW'(1) << owner) : '0;
            led   <= (state == ST_SERVE) ? ~(owner + 3'd1) : LED_OFF;
            busy  <= (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_dip_rr_scheduler.sv
// tb/tb_dip_rr_scheduler.sv - randomized self-checking bench for dip_rr_scheduler against a behavioural model
module tb_dip_rr_scheduler;

    localparam int DEB  = 4;
    localparam int SLOT = 8;

    logic       clk;
    logic       rst;
    logic [6:0] sw;
    logic [2:0] led;
    logic [6:0] grant;
    logic       busy;

    int checks = 0;
    int errors = 0;

    dip_rr_scheduler #(
        .DEBOUNCE_CYCLES(DEB),
        .SLOT_CYCLES(SLOT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sw(sw),
        .led(led),
        .grant(grant),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 serving, 2 gap.
    int       m_mode;
    int       m_owner;
    int       m_age;
    int       m_run [7];
    bit [6:0] m_s1, m_s2, m_deb;
    logic [6:0] exp_grant;
    logic [2:0] exp_led;
    logic       exp_busy;

    function automatic int pick(input bit [6:0] r, input int last);
        for (int k = 1; k <= 7; k++)
            if (r[(last + k) % 7]) return (last + k) % 7;
        return last;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_mode = 0; m_owner = 6; m_age = 0;
            m_s1 = '0; m_s2 = '0; m_deb = '0;
            for (int i = 0; i < 7; i++) m_run[i] = 0;
            exp_grant = '0; exp_led = 3'b111; exp_busy = 1'b0;
            return;
        end
        exp_busy  = (m_mode != 0);
        exp_grant = (m_mode == 1) ? 7'(1 << m_owner) : 7'h00;
        exp_led   = (m_mode == 1) ? 3'(6 - m_owner) : 3'b111;
        case (m_mode)
            0: if (m_deb != 0) begin m_mode = 1; m_owner = pick(m_deb, m_owner); m_age = 0; end
            1: if (!m_deb[m_owner] || m_age == SLOT - 1) m_mode = 2; else m_age++;
            default: if (m_deb != 0) begin m_mode = 1; m_owner = pick(m_deb, m_owner); m_age = 0; end
                     else m_mode = 0;
        endcase
        for (int i = 0; i < 7; i++) begin
            if (m_s2[i] == m_deb[i]) m_run[i] = 0;
            else begin
                m_run[i]++;
                if (m_run[i] == DEB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
            end
        end
        m_s2 = m_s1;
        m_s1 = sw;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; sw = '0;
        repeat (3) cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        rst = 1'b1; sw = 7'h7F;
        repeat (6) begin
            cycle();
            checks++;
            if ({grant, led, busy} !== {7'h00, 3'b111, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: grant=%h led=%b busy=%b, want grant=00 led=111 busy=0", grant, led, busy);
            end
        end
        rst = 1'b0;
        found = 0;
        for (int n = 1; n <= 40 && !found; n++) begin
            cycle();
            checks++;
            if ({grant, led, busy} !== {exp_grant, exp_led, exp_busy}) begin
                errors++;
                $display("FAIL reset_model n=%0d: grant=%h led=%b busy=%b, want %h %b %b", n, grant, led, busy, exp_grant, exp_led, exp_busy);
            end
            if (grant != 0) begin
                found = 1;
                checks++;
                if (grant !== 7'h01) begin
                    errors++;
                    $display("FAIL reset_first_grant: grant=%h, want 01", grant);
                end
            end
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL reset_first_grant: no grant within 40 cycles");
        end
    endtask

    task automatic test_single();
        int first_at;
        int gaps[$];
        bit hit_next;
        do_reset();
        sw = 7'h04;
        first_at = 0;
        for (int n = 1; n <= 60; n++) begin
            cycle();
            checks++;
            if ({grant, led, busy} !== {exp_grant, exp_led, exp_busy}) begin
                errors++;
                $display("FAIL single_model n=%0d: grant=%h led=%b busy=%b, want %h %b %b", n, grant, led, busy, exp_grant, exp_led, exp_busy);
            end
            if (first_at == 0 && grant != 0) begin
                first_at = n;
                checks++;
                if (grant !== 7'h04 || led !== 3'b100) begin
                    errors++;
                    $display("FAIL single_first: grant=%h led=%b, want 04 100", grant, led);
                end
            end else if (first_at != 0 && grant == 0) begin
                gaps.push_back(n);
            end
        end
        checks++;
        if (first_at != DEB + 4) begin
            errors++;
            $display("FAIL single_latency: %0d edges, want %0d", first_at, DEB + 4);
        end
        checks++;
        if (gaps.size() < 4) begin
            errors++;
            $display("FAIL single_gaps: %0d gaps seen, want at least 4", gaps.size());
        end
        foreach (gaps[k]) begin
            checks++;
            if (gaps[k] != first_at + SLOT + (SLOT + 1) * k) begin
                errors++;
                $display("FAIL single_gap_pos k=%0d: cycle %0d, want %0d", k, gaps[k], first_at + SLOT + (SLOT + 1) * k);
            end
        end
        // reset landing while the FSM sits in its one-cycle gap
        hit_next = 0;
        for (int n = 0; n < 20 && !hit_next; n++) begin
            if (m_mode == 2) hit_next = 1;
            else cycle();
        end
        rst = 1'b1;
        cycle();
        checks++;
        if (!hit_next || {grant, led, busy} !== {7'h00, 3'b111, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid_next: hit=%0d grant=%h led=%b busy=%b, want 00 111 0", hit_next, grant, led, busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_bounce();
        int first_at;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            sw = ((c / 2) % 2 == 0) ? 7'h08 : 7'h00;
            cycle();
            checks++;
            if (grant !== 7'h00 || led !== 3'b111) begin
                errors++;
                $display("FAIL bounce_quiet c=%0d: grant=%h led=%b, want 00 111", c, grant, led);
            end
        end
        sw = 7'h08;
        first_at = 0;
        for (int n = 1; n <= 30 && first_at == 0; n++) begin
            cycle();
            checks++;
            if ({grant, led, busy} !== {exp_grant, exp_led, exp_busy}) begin
                errors++;
                $display("FAIL bounce_model n=%0d: grant=%h led=%b busy=%b, want %h %b %b", n, grant, led, busy, exp_grant, exp_led, exp_busy);
            end
            if (grant != 0) first_at = n;
        end
        checks++;
        if (first_at != 8 || grant !== 7'h08 || led !== 3'b011) begin
            errors++;
            $display("FAIL bounce_grant: after %0d edges grant=%h led=%b, want 8 edges 08 011", first_at, grant, led);
        end
    endtask

    task automatic test_wrap();
        logic [6:0] owners[$];
        logic [2:0] leds[$];
        int lens[$];
        int gapl[$];
        int run, zrun;
        logic [6:0] prev;
        do_reset();
        sw = 7'h41;
        prev = '0; run = 0; zrun = 0;
        for (int n = 1; n <= 60; n++) begin
            cycle();
            checks++;
            if ({grant, led, busy} !== {exp_grant, exp_led, exp_busy}) begin
                errors++;
                $display("FAIL wrap_model n=%0d: grant=%h led=%b busy=%b, want %h %b %b", n, grant, led, busy, exp_grant, exp_led, exp_busy);
            end
            if (grant != 0) begin
                if (prev == 0) begin
                    owners.push_back(grant); leds.push_back(led);
                    if (owners.size() > 1) gapl.push_back(zrun);
                    run = 0;
                end
                run++;
            end else begin
                if (prev != 0) begin lens.push_back(run); zrun = 0; end
                zrun++;
            end
            prev = grant;
        end
        checks++;
        if (owners.size() < 4 || lens.size() < 4) begin
            errors++;
            $display("FAIL wrap_count: %0d slots, want at least 4", owners.size());
        end
        for (int k = 0; k < 4 && k < owners.size(); k++) begin
            checks++;
            if (owners[k] !== ((k % 2) ? 7'h40 : 7'h01) || leds[k] !== ((k % 2) ? 3'b000 : 3'b110)) begin
                errors++;
                $display("FAIL wrap_owner k=%0d: grant=%h led=%b, want %h %b", k, owners[k], leds[k],
                         (k % 2) ? 7'h40 : 7'h01, (k % 2) ? 3'b000 : 3'b110);
            end
        end
        foreach (lens[k]) begin
            checks++;
            if (lens[k] != SLOT) begin
                errors++;
                $display("FAIL wrap_slot_len k=%0d: %0d, want %0d", k, lens[k], SLOT);
            end
        end
        foreach (gapl[k]) begin
            checks++;
            if (gapl[k] != 1) begin
                errors++;
                $display("FAIL wrap_gap_len k=%0d: %0d, want 1", k, gapl[k]);
            end
        end
    endtask

    task automatic test_early_release();
        int cnt02, zrun;
        bit done;
        do_reset();
        sw = 7'h22;
        repeat (6) cycle();
        sw = 7'h20;
        cnt02 = 0; zrun = 0; done = 0;
        for (int n = 1; n <= 40 && !done; n++) begin
            cycle();
            checks++;
            if ({grant, led, busy} !== {exp_grant, exp_led, exp_busy}) begin
                errors++;
                $display("FAIL early_model n=%0d: grant=%h led=%b busy=%b, want %h %b %b", n, grant, led, busy, exp_grant, exp_led, exp_busy);
            end
            if (grant == 7'h02) cnt02++;
            else if (grant == 0 && cnt02 > 0) zrun++;
            else if (grant != 0) begin
                done = 1;
                checks++;
                if (grant !== 7'h20 || led !== 3'b001 || zrun != 1) begin
                    errors++;
                    $display("FAIL early_handover: grant=%h led=%b gap=%0d, want 20 001 gap 1", grant, led, zrun);
                end
            end
        end
        // drop sampled one edge before the owner's slot starts: slot cut to DEB+2 cycles
        checks++;
        if (!done || cnt02 != DEB + 2) begin
            errors++;
            $display("FAIL early_slot_len: owner1 held %0d cycles (handover=%0d), want %0d", cnt02, done, DEB + 2);
        end
    endtask

    task automatic test_reset_mid_serve();
        bit found;
        do_reset();
        sw = 7'h50;
        found = 0;
        for (int n = 1; n <= 30 && !found; n++) begin
            cycle();
            if (grant != 0) found = 1;
        end
        checks++;
        if (!found || grant !== 7'h10 || led !== 3'b010) begin
            errors++;
            $display("FAIL midserve_grant: grant=%h led=%b, want 10 010", grant, led);
        end
        repeat (3) cycle();
        rst = 1'b1;
        cycle();
        checks++;
        if ({grant, led, busy} !== {7'h00, 3'b111, 1'b0}) begin
            errors++;
            $display("FAIL midserve_reset_edge: grant=%h led=%b busy=%b, want 00 111 0", grant, led, busy);
        end
        repeat (2) cycle();
        rst = 1'b0;
        found = 0;
        for (int n = 1; n <= 30 && !found; n++) begin
            cycle();
            checks++;
            if ({grant, led, busy} !== {exp_grant, exp_led, exp_busy}) begin
                errors++;
                $display("FAIL midserve_model n=%0d: grant=%h led=%b busy=%b, want %h %b %b", n, grant, led, busy, exp_grant, exp_led, exp_busy);
            end
            if (grant != 0) found = 1;
        end
        checks++;
        if (!found || grant !== 7'h10) begin
            errors++;
            $display("FAIL midserve_regrant: grant=%h, want 10", grant);
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        hold = 0;
        for (int n = 0; n < 1500; n++) begin
            if (hold == 0) begin
                sw   = 7'($urandom);
                hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(6, 40);
            end
            hold--;
            rst = ($urandom_range(0, 199) == 0);
            cycle();
            checks++;
            if ({grant, led, busy} !== {exp_grant, exp_led, exp_busy}) begin
                errors++;
                $display("FAIL random_model n=%0d sw=%h: grant=%h led=%b busy=%b, want %h %b %b", n, sw, grant, led, busy, exp_grant, exp_led, exp_busy);
            end
            checks++;
            if ($countones(grant) > 1) begin
                errors++;
                $display("FAIL random_onehot n=%0d: grant=%h, want at most one bit", n, grant);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw  = '0;
        test_reset();
        test_single();
        test_bounce();
        test_wrap();
        test_early_release();
        test_reset_mid_serve();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dip_rr_scheduler.md
DIP_RR_SCHEDULER -- requirements
Module: dip_rr_scheduler

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required before a switch change is accepted.
REQ-002 Parameter SLOT_CYCLES, default 50000000: length of one display time slot in clk cycles.
REQ-003 Port clk  input  1  single system clock; all logic on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port sw  input  7  raw DIP switches, asynchronous; sw[0] is switch a, sw[6] is switch g; 1 = request.
REQ-006 Port led  output  3  active-low LED code of the granted switch; 3'b111 = all off.
REQ-007 Port grant  output  7  one-hot index of the switch currently owning the LEDs; all zero when none.
REQ-008 Port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-009 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 Debounced request i SHALL change only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any intervening match SHALL clear that switch's counter.
REQ-011 The FSM SHALL have states IDLE, SERVE and NEXT.
REQ-012 IDLE: grant=0, led=3'b111; go to SERVE when any debounced request is high.
REQ-013 On entry to SERVE, the owner SHALL be the first requesting index found searching upward from (last owner + 1) mod 7 with wrap from 6 to 0.
REQ-014 SERVE: grant one-hot at owner index; led = ~(owner+1) in 3 bits (a=110, b=101, c=100, d=011, e=010, f=001, g=000).
REQ-015 SERVE SHALL go to NEXT when the slot counter reaches SLOT_CYCLES-1, or on the cycle after the owner's debounced request falls, whichever is first.
REQ-016 NEXT SHALL last exactly one cycle with grant=0 and led=3'b111, then go to SERVE if any request remains, else to IDLE.
REQ-017 The slot counter SHALL clear on every entry to SERVE.
REQ-018 A lone requester SHALL be re-granted after each one-cycle NEXT gap.
REQ-019 Requests arriving during SERVE SHALL NOT preempt the owner.
REQ-020 led, grant and busy SHALL be registered outputs.
REQ-021 Latency from sw change to grant/led change SHALL be exactly DEBOUNCE_CYCLES+4 clk edges when starting from IDLE.
REQ-022 grant SHALL never have more than one bit set.

Reset
REQ-023 With rst high at a clk edge: FSM=IDLE, last owner=6, all debounce and slot counters=0, debounced requests=0, synchronizers=0.
REQ-024 Outputs SHALL be led=3'b111, grant=0, busy=0 from the first edge with rst high, including when rst is asserted mid-SERVE or mid-NEXT.
REQ-025 After rst is released, the first grant SHALL search from index 0.

Structure
REQ-026 Shared package dip_pkg SHALL hold NUM_SW=7, LED_OFF=3'b111 and the FSM state encodings.
REQ-027 Per-switch synchronizer plus debounce SHALL be sub-module dip_debounce, instantiated 7 times.

Verification (DEBOUNCE_CYCLES=4, SLOT_CYCLES=8)
REQ-028 Reset: hold rst with sw=7'h7F -> led=111, grant=0 and busy=0 throughout; after release, first grant=7'h01.
REQ-029 Single switch: sw=7'h04 stable from IDLE -> grant=7'h04 and led=100 exactly 8 edges later; one-cycle gap every 9 cycles.
REQ-030 Bounce: sw[3] toggles every 2 cycles for 20 cycles, then stays 1 -> no grant during toggling; grant=7'h08, led=011 after 8 stable edges.
REQ-031 Round-robin wrap: sw=7'h41 -> owners alternate 0,6,0,6, each 8-cycle slot separated by a 1-cycle gap; led alternates 110/000.
REQ-032 Early release: owner index 1 (led=101) drops sw[1] mid-slot with sw[5] set -> NEXT one cycle after debounced fall, then grant=7'h20, led=001.
REQ-033 Reset mid-SERVE: assert rst during slot of index 4 -> led=111, grant=0, busy=0 at that edge; after release the first grant goes to the lowest requesting index.
